// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/stall sequencer for multi-cycle FP ops.
// Fixed-latency ops (fadd/fsub/fmul) count down. Iterative ops (fdiv/fsqrt)
// use a start/done handshake with a shared unit. Each op ends with a
// one-cycle write-back strobe.
// Optional: define FPU_WDOG_EN to add an iterative-unit watchdog.
module fpu_issue_ctrl #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int WDOG_CYC = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [4:0] i_alu_op,
  input  logic [4:0] i_rd,
  input  logic       i_flush,
  input  logic       i_fu_done,
  output logic       o_fu_start,
  output logic       o_fu_op,
  output logic       o_fu_abort,
  output logic       o_stall,
  output logic       o_busy,
  output logic       o_wb_vld,
  output logic [4:0] o_wb_rd,
  output logic       o_wdog_err
);

  localparam int MAXL = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int MAXV = (MAXL > WDOG_CYC) ? MAXL : WDOG_CYC;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [4:0] OP_FADD  = 5'b01010;
  localparam logic [4:0] OP_FSUB  = 5'b01011;
  localparam logic [4:0] OP_FMUL  = 5'b01100;
  localparam logic [4:0] OP_FDIV  = 5'b01101;
  localparam logic [4:0] OP_FSQRT = 5'b10000;

  typedef enum logic [1:0] {IDLE, FIXED, ITER, WB} state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]    r_rd;
  logic          r_op;
  logic          r_fu_start, r_abort, r_wdog_err;
  logic          w_abort_nxt, w_err_nxt;
  logic          w_fixed, w_iter, w_mul, w_accept;

  assign w_mul    = (i_alu_op == OP_FMUL);
  assign w_fixed  = (i_alu_op == OP_FADD) || (i_alu_op == OP_FSUB) || w_mul;
  assign w_iter   = (i_alu_op == OP_FDIV) || (i_alu_op == OP_FSQRT);
  assign w_accept = (r_state == IDLE) && i_valid && (w_fixed || w_iter) && !i_flush;

  // Next-state, counter and pulse generation
  always_comb begin
    w_nxt       = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = 1'b0;
    w_err_nxt   = r_wdog_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_fixed) begin
            // LAT=1 skips FIXED entirely; the count is then unused
            w_cnt_nxt = w_mul ? CW'(LAT_MUL - 1) : CW'(LAT_ADD - 1);
            w_nxt     = ((w_mul ? LAT_MUL : LAT_ADD) == 1) ? WB : FIXED;
          end else begin
            w_cnt_nxt = '0;
            w_nxt     = ITER;
          end
        end
      end
      FIXED: begin
        if (i_flush) begin
          w_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CW'(1)) w_nxt = WB;
        end
      end
      ITER: begin
        if (i_flush) begin
          // flush beats a same-cycle done
          w_nxt       = IDLE;
          w_abort_nxt = 1'b1;
        end else if (i_fu_done) begin
          w_nxt = WB;
        end else begin
`ifdef FPU_WDOG_EN
          // r_cnt is 0 in the first ITER cycle, so WDOG_CYC-1 marks the last allowed one
          if (r_cnt == CW'(WDOG_CYC - 1)) begin
            w_nxt       = IDLE;
            w_abort_nxt = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
`else
          w_nxt = ITER;
`endif
        end
      end
      WB:      w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // State, counter, latched op info and registered pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_op       <= 1'b0;
      r_fu_start <= 1'b0;
      r_abort    <= 1'b0;
      r_wdog_err <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fu_start <= w_accept && w_iter;
      r_abort    <= w_abort_nxt;
      r_wdog_err <= w_err_nxt;
      if (w_accept) begin
        r_rd <= i_rd;
        r_op <= (i_alu_op == OP_FSQRT);
      end
    end
  end

  assign o_fu_start = r_fu_start;
  assign o_fu_op    = r_op;
  assign o_fu_abort = r_abort;
  assign o_busy     = (r_state != IDLE);
  assign o_stall    = w_accept || (r_state == FIXED) || (r_state == ITER);
  assign o_wb_vld   = (r_state == WB);
  assign o_wb_rd    = (r_state == WB) ? r_rd : 5'd0;
`ifdef FPU_WDOG_EN
  assign o_wdog_err = r_wdog_err;
`else
  assign o_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: scoreboard bench for fpu_issue_ctrl.
// DUT built with LAT_ADD=3, LAT_MUL=1, WDOG_CYC=8. Watchdog cases run when
// FPU_WDOG_EN is defined; otherwise an indefinite ITER wait is checked.
module tb_fpu_issue_ctrl;
  localparam logic [4:0] OP_FADD  = 5'b01010;
  localparam logic [4:0] OP_FMUL  = 5'b01100;
  localparam logic [4:0] OP_FDIV  = 5'b01101;
  localparam logic [4:0] OP_FSQRT = 5'b10000;
  localparam logic [4:0] OP_FSGNJ = 5'b10001;

  typedef struct {
    logic [4:0] rd;
    int         cyc;
  } wb_exp_t;

  logic       gclk = 1'b0;
  logic       grst_n;
  logic       valid, flush, done;
  logic [4:0] op, rd;
  logic       fu_start, fu_op, fu_abort, stall, busy, wb_vld, wdog_err;
  logic [4:0] wb_rd;

  int      cyc = 0;
  int      n_chk = 0;
  int      n_fail = 0;
  wb_exp_t sb[$];

  fpu_issue_ctrl #(.LAT_ADD(3), .LAT_MUL(1), .WDOG_CYC(8)) u_dut (
    .i_clk(gclk), .i_rst_n(grst_n), .i_valid(valid), .i_alu_op(op),
    .i_rd(rd), .i_flush(flush), .i_fu_done(done),
    .o_fu_start(fu_start), .o_fu_op(fu_op), .o_fu_abort(fu_abort),
    .o_stall(stall), .o_busy(busy), .o_wb_vld(wb_vld), .o_wb_rd(wb_rd),
    .o_wdog_err(wdog_err)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // advance one cycle; inputs change 1 time unit after the edge, checks at +3
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] o, input logic [4:0] r,
                       input logic f, input logic d);
    valid = v; op = o; rd = r; flush = f; done = d;
    #2;
  endtask

  task automatic push(input logic [4:0] r, input int c);
    wb_exp_t e;
    e.rd = r; e.cyc = c;
    sb.push_back(e);
  endtask

  // write-back monitor: every strobe must match the oldest expectation
  always @(negedge gclk) begin
    if (grst_n && wb_vld) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 1, 0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        chk("wb_rd", int'(wb_rd), int'(e.rd));
        chk("wb_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    int t;
    grst_n = 1'b0;
    valid = 0; op = 0; rd = 0; flush = 0; done = 0;
    repeat (2) @(posedge gclk);
    #3;
    chk("rst_busy", busy, 0);     chk("rst_stall", stall, 0);
    chk("rst_wb", wb_vld, 0);     chk("rst_wbrd", wb_rd, 0);
    chk("rst_start", fu_start, 0); chk("rst_abort", fu_abort, 0);
    chk("rst_err", wdog_err, 0);  chk("rst_fuop", fu_op, 0);
    @(negedge gclk); grst_n = 1'b1;
    tick();

    // fadd rd=5, LAT 3; write-back cycle also carries a flush and a new op
    drive(1, OP_FADD, 5, 0, 0);
    chk("fadd_stall0", stall, 1);
    push(5, cyc + 3);
    tick(); drive(0, 0, 0, 0, 0); chk("fadd_stall1", stall, 1);
    tick();                       chk("fadd_stall2", stall, 1);
    tick(); drive(1, OP_FADD, 9, 1, 0);
    chk("fadd_wb", wb_vld, 1); chk("fadd_wb_stall", stall, 0);
    tick(); drive(0, 0, 0, 0, 0); chk("fadd_idle", busy, 0);

    // fmul rd=7 with LAT 1: straight to WB
    drive(1, OP_FMUL, 7, 0, 0);
    chk("fmul_stall", stall, 1);
    push(7, cyc + 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("fmul_wb", wb_vld, 1); chk("fmul_stall1", stall, 0);
    tick(); chk("fmul_idle", busy, 0);

    // fsqrt rd=3, done 12 cycles after accept
    drive(1, OP_FSQRT, 3, 0, 0);
    t = cyc;
    tick(); drive(0, 0, 0, 0, 0);
    chk("sqrt_start", fu_start, 1); chk("sqrt_op", fu_op, 1);
    chk("sqrt_stall", stall, 1);
    tick(); chk("sqrt_start_off", fu_start, 0);
    while (cyc < t + 12) begin
      chk("sqrt_stall_iter", stall, 1);
      tick();
    end
    drive(0, 0, 0, 0, 1);
    push(3, cyc + 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("sqrt_wb", wb_vld, 1);
    tick(); chk("sqrt_idle", busy, 0);

    // fdiv: flush and done together -> abort, no write-back
    drive(1, OP_FDIV, 9, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("div_start", fu_start, 1); chk("div_op", fu_op, 0);
    tick(); drive(0, 0, 0, 1, 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("div_abort", fu_abort, 1); chk("div_idle", busy, 0);
    tick(); chk("div_abort_off", fu_abort, 0);

    // flush during FIXED: no write-back, no abort
    drive(1, OP_FADD, 4, 0, 0);
    tick(); drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("fix_flush_idle", busy, 0); chk("fix_flush_abort", fu_abort, 0);
    // flush alongside a valid op in IDLE blocks the accept
    drive(1, OP_FADD, 4, 1, 0);
    chk("idle_flush_stall", stall, 0);
    tick(); drive(0, 0, 0, 0, 0); chk("idle_flush_busy", busy, 0);

    // non-multicycle op and a stray done
    drive(1, OP_FSGNJ, 6, 0, 0);
    chk("sgnj_stall", stall, 0);
    tick(); drive(0, 0, 0, 0, 1); chk("sgnj_busy", busy, 0);
    tick(); drive(0, 0, 0, 0, 0); chk("stray_busy", busy, 0);
    tick();

`ifdef FPU_WDOG_EN
    // no done: abort after 8 ITER cycles, sticky error
    drive(1, OP_FDIV, 2, 0, 0);
    t = cyc;
    tick(); drive(0, 0, 0, 0, 0);
    while (cyc < t + 8) tick();
    chk("wd_last_busy", busy, 1); chk("wd_last_abort", fu_abort, 0);
    tick();
    chk("wd_abort", fu_abort, 1); chk("wd_idle", busy, 0);
    chk("wd_err", wdog_err, 1);
    tick(); chk("wd_abort_off", fu_abort, 0); chk("wd_err_hold", wdog_err, 1);
    // done on the limit cycle wins
    drive(1, OP_FDIV, 11, 0, 0);
    t = cyc;
    tick(); drive(0, 0, 0, 0, 0);
    while (cyc < t + 8) tick();
    drive(0, 0, 0, 0, 1);
    push(11, cyc + 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("wd_done_abort", fu_abort, 0); chk("wd_done_wb", wb_vld, 1);
    repeat (3) tick();
    chk("wd_err_sticky", wdog_err, 1);
`else
    // without the watchdog ITER waits as long as it takes
    drive(1, OP_FDIV, 2, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    repeat (20) tick();
    chk("nowd_busy", busy, 1); chk("nowd_abort", fu_abort, 0);
    chk("nowd_err", wdog_err, 0);
    drive(0, 0, 0, 0, 1);
    push(2, cyc + 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("nowd_wb", wb_vld, 1);
    tick();
`endif

    // async reset mid-op: immediate IDLE, no abort, error cleared
    drive(1, OP_FSQRT, 1, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    #1 grst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_abort", fu_abort, 0);
    chk("arst_err", wdog_err, 0); chk("arst_start", fu_start, 0);
    tick();
    chk("arst_abort2", fu_abort, 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequences multi-cycle floating-point operations after instruction decode.
- Holds the pipeline with a stall while an FP op is in flight:
  - fadd.s, fsub.s and fmul.s run on fixed-latency units.
  - fdiv.s and fsqrt.s run on a shared iterative unit, driven through a start/done handshake.
- When the op completes, issues a one-cycle FP register-file write-back strobe.
- Single-cycle FP ops and integer ops pass through untouched.

Parameters:
- LAT_ADD, 3, cycles from accept to write-back for fadd.s/fsub.s (>=1)
- LAT_MUL, 4, cycles from accept to write-back for fmul.s (>=1)
- WDOG_CYC, 64, iterative-unit watchdog limit in cycles (used only with FPU_WDOG_EN)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  decoded instruction present this cycle
- i_alu_op  in  5  decoder ALU op code: 01010 fadd, 01011 fsub, 01100 fmul, 01101 fdiv, 10000 fsqrt
- i_rd  in  5  destination FP register
- i_flush  in  1  pipeline flush; kills the op in flight
- i_fu_done  in  1  iterative unit result ready
- o_fu_start  out  1  one-cycle start pulse to the iterative unit
- o_fu_op  out  1  iterative op select: 0 = fdiv, 1 = fsqrt
- o_fu_abort  out  1  one-cycle abort to the iterative unit
- o_stall  out  1  hold fetch/decode
- o_busy  out  1  state != IDLE
- o_wb_vld  out  1  FP register-file write enable, one cycle
- o_wb_rd  out  5  write-back destination
- o_wdog_err  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset state: IDLE, cnt=0, rd_q=0. All outputs are 0.
- States: IDLE, FIXED, ITER, WB.
- Op classes:
  - fixed = fadd/fsub/fmul.
  - iter = fdiv/fsqrt.
  - Any other code is ignored and never stalls.
- Accept: state IDLE, i_valid, op is fixed or iter, and !i_flush. On accept, rd_q <= i_rd.
- IDLE, fixed op accepted:
  - cnt <= LAT-1, where LAT = LAT_MUL for fmul, else LAT_ADD.
  - Next state FIXED, or WB directly when LAT=1.
- IDLE, iter op accepted:
  - Next state ITER; op_q latched.
  - o_fu_start is registered: high in the first ITER cycle only, with o_fu_op valid alongside it.
- FIXED: cnt decrements each cycle. When cnt==1, next state WB.
- ITER: i_fu_done (including in the start cycle) -> WB.
- WB:
  - o_wb_vld=1 and o_wb_rd=rd_q for exactly one cycle.
  - Next state is always IDLE. i_valid is ignored in WB.
- Write-back timing: accepting at cycle T gives o_wb_vld at T+LAT for fixed ops, and at one cycle after done is sampled for iter ops.
- o_stall (combinational) = (IDLE & accept) | FIXED | ITER. It is 0 in WB, so the held instruction retires in the write-back cycle.
- Flush: i_flush in FIXED or ITER -> IDLE next cycle, with no write-back.
  - If flushed in ITER, o_fu_abort is high for one cycle, the next cycle.
  - Flush has priority over i_fu_done in the same cycle.
  - Flush in WB has no effect; the write-back completes.
- i_fu_done outside ITER is ignored.
- Counter width is $clog2(max(LAT_ADD, LAT_MUL, WDOG_CYC)+1). No wrap-around in normal operation.
- Asynchronous reset mid-operation returns to IDLE immediately, with no abort pulse.

Optional Feature:
- Macro: FPU_WDOG_EN.
- With FPU_WDOG_EN defined:
  - ITER counts cycles from entry.
  - If WDOG_CYC cycles elapse without i_fu_done: one-cycle o_fu_abort, o_wdog_err <= 1 (sticky until reset), next state IDLE, no write-back.
  - If i_fu_done arrives on the limit cycle, done wins.
- Without FPU_WDOG_EN: o_wdog_err is tied 0, and ITER waits indefinitely.

Test Plan:
- fadd, rd=5, accepted at cycle 10, LAT_ADD=3 -> o_stall high in cycles 10-12; o_wb_vld=1, o_wb_rd=5 in cycle 13 only; o_busy low from 14.
- fmul, rd=7, with LAT_MUL overridden to 1 -> IDLE->WB; o_stall high one cycle; o_wb_vld the next cycle.
- fsqrt, rd=3 -> o_fu_start=1, o_fu_op=1 one cycle after accept; i_fu_done 12 cycles later -> o_wb_vld, rd=3 the next cycle; o_stall high throughout ITER.
- fdiv in ITER with i_flush and i_fu_done in the same cycle -> no o_wb_vld; o_fu_abort pulse the next cycle; state IDLE.
- i_alu_op=10001 (fsgnj) with i_valid -> o_stall=0, o_busy=0; stray i_fu_done in IDLE -> no effect.
- With FPU_WDOG_EN and WDOG_CYC=8, fdiv with no done -> abort pulse after 8 ITER cycles; o_wdog_err=1 held until i_rst_n low.
